// File: rtl/irrigation_pkg.sv
// irrigation_pkg: tank thresholds, flow-rate defaults and the probe bundle shared by the plant and controller benches
package irrigation_pkg;
  localparam int CAP_DEF     = 15;
  localparam int LOW_TH_DEF  = 3;
  localparam int MID_TH_DEF  = 8;
  localparam int HIGH_TH_DEF = 13;
  localparam int FILL_DEF    = 2;
  localparam int ASP_R_DEF   = 3;
  localparam int GOT_R_DEF   = 1;
  localparam int DIV_DEF     = 4;
  typedef struct packed {
    logic low;
    logic mid;
    logic high;
  } probes_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler strobing tick for one clk cycle out of every DIV (ports: clk, rst in; tick out)
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap;
  always_comb begin
    wrap  = cnt_q == LAST;
    tick  = wrap & ~rst;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/tank_level_model.sv
// tank_level_model: water-tank plant integrating fill/drain per tick into level, probes and sticky overflow/dry flags
// ports: clk, rst; watter_supply/asp/got actuators; fault_inj forces high probe;
// level, low/mid/high probes, tick strobe, overflow/dry sticky flags out
module tank_level_model
  import irrigation_pkg::*;
#(
  parameter int CAP     = CAP_DEF,
  parameter int LOW_TH  = LOW_TH_DEF,
  parameter int MID_TH  = MID_TH_DEF,
  parameter int HIGH_TH = HIGH_TH_DEF,
  parameter int FILL    = FILL_DEF,
  parameter int ASP_R   = ASP_R_DEF,
  parameter int GOT_R   = GOT_R_DEF,
  parameter int DIV     = DIV_DEF,
  localparam int LW     = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          watter_supply,
  input  logic          asp,
  input  logic          got,
  input  logic          fault_inj,
  output logic [LW-1:0] level,
  output logic          low,
  output logic          mid,
  output logic          high,
  output logic          tick,
  output logic          overflow,
  output logic          dry
);
  localparam int SW = LW + 3;
  localparam logic signed [SW-1:0] FILL_S = SW'(FILL);
  localparam logic signed [SW-1:0] ASP_S  = SW'(ASP_R);
  localparam logic signed [SW-1:0] GOT_S  = SW'(GOT_R);
  localparam logic signed [SW-1:0] CAP_S  = SW'(CAP);
  localparam logic [LW-1:0] CAP_L  = LW'(CAP);
  localparam logic [LW-1:0] LOW_L  = LW'(LOW_TH);
  localparam logic [LW-1:0] MID_L  = LW'(MID_TH);
  localparam logic [LW-1:0] HIGH_L = LW'(HIGH_TH);
  logic [LW-1:0] level_q, level_d, next_lvl;
  logic signed [SW-1:0] sum;
  probes_t probes_q, probes_d;
  logic overflow_q, overflow_d, dry_q, dry_d;
  tick_divider #(.DIV(DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );
  // probes follow level_d every cycle so fault_inj reaches high with one cycle of latency even between ticks
  always_comb begin
    sum        = $signed({3'b000, level_q}) + (watter_supply ? FILL_S : '0) - (asp ? ASP_S : '0) - (got ? GOT_S : '0);
    next_lvl   = sum[SW-1] ? '0 : sum > CAP_S ? CAP_L : sum[LW-1:0];
    level_d    = tick ? next_lvl : level_q;
    probes_d   = '{low: level_d >= LOW_L, mid: level_d >= MID_L, high: (level_d >= HIGH_L) | fault_inj};
    overflow_d = overflow_q | (tick & watter_supply & (level_q == CAP_L));
    dry_d      = dry_q | (tick & (asp | got) & (level_q == '0));
  end
  always_ff @(posedge clk) begin
    level_q    <= rst ? '0 : level_d;
    probes_q   <= rst ? '0 : probes_d;
    overflow_q <= rst ? 1'b0 : overflow_d;
    dry_q      <= rst ? 1'b0 : dry_d;
  end
  assign level    = level_q;
  assign low      = probes_q.low;
  assign mid      = probes_q.mid;
  assign high     = probes_q.high;
  assign overflow = overflow_q;
  assign dry      = dry_q;
endmodule

// File: tb/tb_tank_level_model.sv
// tb_tank_level_model: directed table plus hand sequences checking the tank plant at default parameters
module tb_tank_level_model;
  logic clk = 1'b0, rst = 1'b1, watter_supply = 1'b0, asp = 1'b0, got = 1'b0, fault_inj = 1'b0;
  logic [3:0] level;
  logic low, mid, high, tick, overflow, dry;
  int total = 0, passed = 0;
  typedef struct {
    logic s, a, g;
    int   lvl;
    logic lo, mi, hi, ov, dr;
  } vec_t;
  vec_t v[17];
  tank_level_model dut (
    .clk          (clk),
    .rst          (rst),
    .watter_supply(watter_supply),
    .asp          (asp),
    .got          (got),
    .fault_inj    (fault_inj),
    .level        (level),
    .low          (low),
    .mid          (mid),
    .high         (high),
    .tick         (tick),
    .overflow     (overflow),
    .dry          (dry)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    int n = 0;
    while (!tick && n < 12) begin
      cyc();
      n++;
    end
    if (!tick) chk("tick_timeout", 0, 1);
  endtask
  task automatic all_chk(input string tag, input int lvl, input logic lo, mi, hi, ov, dr);
    chk({tag, "_level"}, int'(level), lvl);
    chk({tag, "_low"}, int'(low), int'(lo));
    chk({tag, "_mid"}, int'(mid), int'(mi));
    chk({tag, "_high"}, int'(high), int'(hi));
    chk({tag, "_overflow"}, int'(overflow), int'(ov));
    chk({tag, "_dry"}, int'(dry), int'(dr));
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0,  4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2]  = '{1'b1, 1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[3]  = '{1'b1, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[5]  = '{1'b1, 1'b0, 1'b0, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[6]  = '{1'b1, 1'b0, 1'b0, 14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v[7]  = '{1'b1, 1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v[8]  = '{1'b1, 1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v[9]  = '{1'b0, 1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v[10] = '{1'b0, 1'b1, 1'b0, 12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[11] = '{1'b0, 1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[12] = '{1'b1, 1'b1, 1'b1,  6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[13] = '{1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[14] = '{1'b0, 1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[15] = '{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v[16] = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    repeat (2) cyc();
    all_chk("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_tick", int'(tick), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("first_tick_gap%0d", i), int'(tick), 0);
      cyc();
    end
    chk("first_tick", int'(tick), 1);
    for (int i = 0; i < 17; i++) begin
      watter_supply = v[i].s;
      asp = v[i].a;
      got = v[i].g;
      wait_tick();
      cyc();
      all_chk($sformatf("vec%0d", i), v[i].lvl, v[i].lo, v[i].mi, v[i].hi, v[i].ov, v[i].dr);
      chk($sformatf("vec%0d_tick_low", i), int'(tick), 0);
    end
    watter_supply = 1'b0;
    asp = 1'b0;
    got = 1'b0;
    fault_inj = 1'b1;
    chk("fault_latency", int'(high), 0);
    cyc();
    all_chk("fault", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    asp = 1'b1;
    wait_tick();
    cyc();
    all_chk("dry", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    asp = 1'b0;
    fault_inj = 1'b0;
    cyc();
    chk("fault_release", int'(high), 0);
    watter_supply = 1'b1;
    cyc();
    watter_supply = 1'b0;
    wait_tick();
    cyc();
    chk("pulse_ignored", int'(level), 0);
    watter_supply = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      cyc();
    end
    all_chk("ramp10", 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    all_chk("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_tick", int'(tick), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("restart_gap%0d", i), int'(tick), 0);
      cyc();
    end
    chk("restart_tick", int'(tick), 1);
    chk("restart_hold", int'(level), 0);
    cyc();
    chk("restart_fill", int'(level), 2);
    watter_supply = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
